// File: rtl/freq_gen_pkg.sv
// Shared types and default widths for the programmable square-wave generator.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package freq_gen_pkg;

    localparam int DIV_WIDTH_DEF   = 12;
    localparam int BURST_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

endpackage

// File: rtl/half_timer.sv
// Loadable down-counter timing one half-period; tc flags the last cycle of a phase.
// Latency: load takes effect the cycle after it is asserted; tc is combinational from the count.
// Backpressure: none; en low freezes the count.
module half_timer #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] cnt;

    // Reload on request, otherwise count down and park at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en) begin
            if (load) begin
                cnt <= load_val;
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/freq_generator.sv
// 50% duty square-wave source, half-period in clk cycles, burst of N periods or continuous.
// Latency: sig_out/busy rise the cycle after start; new half-period applies from the next period boundary.
// Backpressure: cfg_ready low while a pending config waits for a boundary, and whenever ena is low.
module freq_generator
    import freq_gen_pkg::*;
#(
    parameter int DIV_WIDTH   = DIV_WIDTH_DEF,
    parameter int BURST_WIDTH = BURST_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [DIV_WIDTH-1:0]   cfg_half,
    input  logic [BURST_WIDTH-1:0] cfg_bursts,
    input  logic                   start,
    input  logic                   stop,
    output logic                   sig_out,
    output logic                   busy,
    output logic                   done
);

    state_t                 state, state_nxt;
    logic [DIV_WIDTH-1:0]   active_half;
    logic [BURST_WIDTH-1:0] active_bursts;
    logic [DIV_WIDTH-1:0]   pending_half;
    logic                   pending_vld;
    logic [BURST_WIDTH-1:0] burst_left;
    logic                   stop_req;
    logic                   done_q;

    logic                   tmr_load;
    logic [DIV_WIDTH-1:0]   tmr_val;
    logic                   tmr_tc;

    logic                   is_idle;
    logic                   cfg_hs;
    logic                   start_go;
    logic                   boundary;
    logic                   finish;
    logic [DIV_WIDTH-1:0]   start_half;
    logic [DIV_WIDTH-1:0]   next_half;

    // A half-period of 0 behaves as 1; the counter runs from N-1 down to 0.
    function automatic logic [DIV_WIDTH-1:0] half_m1(input logic [DIV_WIDTH-1:0] h);
        return (h == '0) ? '0 : h - 1'b1;
    endfunction

    assign is_idle    = (state == IDLE);
    assign cfg_ready  = ena & (is_idle | ~pending_vld);
    assign cfg_hs     = cfg_valid & cfg_ready;
    assign start_go   = ena & is_idle & start;
    assign boundary   = ena & (state == LOW) & tmr_tc;
    assign finish     = boundary &
                        (stop_req | ((active_bursts != '0) && (burst_left == BURST_WIDTH'(1))));
    // A config taken in the same cycle as start is the one this run uses.
    assign start_half = cfg_hs ? cfg_half : active_half;
    assign next_half  = pending_vld ? pending_half : active_half;

    assign sig_out = (state == HIGH);
    assign busy    = ~is_idle;
    assign done    = done_q;

    half_timer #(.W(DIV_WIDTH)) u_half_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (ena),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    // Next-state and timer reload selection.
    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_val   = half_m1(active_half);
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = HIGH;
                    tmr_load  = 1'b1;
                    tmr_val   = half_m1(start_half);
                end
            end
            HIGH: begin
                if (tmr_tc) begin
                    state_nxt = LOW;
                    tmr_load  = 1'b1;
                end
            end
            LOW: begin
                if (tmr_tc) begin
                    if (finish) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = HIGH;
                        tmr_load  = 1'b1;
                        tmr_val   = half_m1(next_half);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register; frozen while ena is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (ena) begin
            state <= state_nxt;
        end
    end

    // Config capture: straight to active when idle, into the pending slot when running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_half   <= '0;
            active_bursts <= '0;
            pending_half  <= '0;
            pending_vld   <= 1'b0;
        end else if (ena) begin
            if (cfg_hs && is_idle) begin
                active_half   <= cfg_half;
                active_bursts <= cfg_bursts;
            end else if (cfg_hs) begin
                pending_half <= cfg_half;
                pending_vld  <= 1'b1;
            end else if (boundary && pending_vld) begin
                active_half <= pending_half;
                pending_vld <= 1'b0;
            end
        end
    end

    // Burst countdown, one step per completed period in burst mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_left <= '0;
        end else if (ena) begin
            if (start_go) begin
                burst_left <= cfg_hs ? cfg_bursts : active_bursts;
            end else if (boundary && (active_bursts != '0)) begin
                burst_left <= burst_left - 1'b1;
            end
        end
    end

    // Stop request latched while running, dropped when the run ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stop_req <= 1'b0;
        end else if (ena) begin
            if (finish) begin
                stop_req <= 1'b0;
            end else if (!is_idle && stop) begin
                stop_req <= 1'b1;
            end
        end
    end

    // Single-cycle done on the transition into IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= 1'b0;
        end else begin
            done_q <= finish;
        end
    end

endmodule

// File: tb/tb_freq_generator.sv
module tb_freq_generator;

    localparam int DW = 12;
    localparam int BW = 8;

    logic          clk;
    logic          rst_n;
    logic          ena;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [DW-1:0] cfg_half;
    logic [BW-1:0] cfg_bursts;
    logic          start;
    logic          stop;
    logic          sig_out;
    logic          busy;
    logic          done;

    int tests_run;
    int tests_failed;

    freq_generator #(.DIV_WIDTH(DW), .BURST_WIDTH(BW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_half   (cfg_half),
        .cfg_bursts (cfg_bursts),
        .start      (start),
        .stop       (stop),
        .sig_out    (sig_out),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({sig_out, busy, done, cfg_ready} !== 4'b0001) begin
            $display("FAIL reset_vals: got sig/busy/done/rdy=%b expected 0001", {sig_out, busy, done, cfg_ready});
            tests_failed++;
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({sig_out, busy, done, cfg_ready} !== 4'b0001) begin
            $display("FAIL reset_release: got sig/busy/done/rdy=%b expected 0001", {sig_out, busy, done, cfg_ready});
            tests_failed++;
        end
    endtask

    // N=3, 2 periods: done 13 cycles after start.
    task automatic test_burst();
        logic [0:14] e_sig, e_busy, e_done;
        e_sig  = 15'b0_111_000_111_000_00;
        e_busy = 15'b0_111111111111_00;
        e_done = 15'b0_000000000000_10;
        cfg_valid = 1'b1; cfg_half = 12'd3; cfg_bursts = 8'd2; start = 1'b1;
        tests_run++;
        if (cfg_ready !== 1'b1) begin
            $display("FAIL burst_rdy0: got %b expected 1", cfg_ready);
            tests_failed++;
        end
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            cfg_valid = 1'b0; start = 1'b0;
            tests_run++;
            if ({sig_out, busy, done} !== {e_sig[k], e_busy[k], e_done[k]}) begin
                $display("FAIL burst_c%0d: got sig/busy/done=%b expected %b", k,
                         {sig_out, busy, done}, {e_sig[k], e_busy[k], e_done[k]});
                tests_failed++;
            end
        end
    endtask

    // Half-period 0 behaves as 1.
    task automatic test_half_zero();
        logic [0:4] e_sig, e_busy, e_done;
        e_sig  = 5'b01000;
        e_busy = 5'b01100;
        e_done = 5'b00010;
        cfg_valid = 1'b1; cfg_half = 12'd0; cfg_bursts = 8'd1; start = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            cfg_valid = 1'b0; start = 1'b0;
            tests_run++;
            if ({sig_out, busy, done} !== {e_sig[k], e_busy[k], e_done[k]}) begin
                $display("FAIL half0_c%0d: got sig/busy/done=%b expected %b", k,
                         {sig_out, busy, done}, {e_sig[k], e_busy[k], e_done[k]});
                tests_failed++;
            end
        end
    endtask

    // start+stop together in IDLE: run continues; a later stop in HIGH ends after that period.
    task automatic test_start_stop();
        logic [0:8] e_sig, e_busy, e_done;
        e_sig  = 9'b0_101010_00;
        e_busy = 9'b0_111111_00;
        e_done = 9'b0_000000_10;
        cfg_valid = 1'b1; cfg_half = 12'd1; cfg_bursts = 8'd0; start = 1'b1; stop = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            cfg_valid = 1'b0; start = 1'b0;
            stop = (k == 5);
            tests_run++;
            if ({sig_out, busy, done} !== {e_sig[k], e_busy[k], e_done[k]}) begin
                $display("FAIL startstop_c%0d: got sig/busy/done=%b expected %b", k,
                         {sig_out, busy, done}, {e_sig[k], e_busy[k], e_done[k]});
                tests_failed++;
            end
        end
        stop = 1'b0;
    endtask

    // Continuous N=4, reconfigure to 2 mid-run, third config (3) held off, then stop.
    task automatic test_reload();
        logic [0:35] e_sig, e_busy, e_done, e_rdy;
        e_sig  = 36'b0_1111_0000_1111_0000_11_00_111_000_111_000_000;
        e_rdy  = 36'b1_1111111111_000000_1_000_111111111111111;
        e_busy = '0;
        for (int i = 1; i <= 32; i++) e_busy[i] = 1'b1;
        e_done = '0;
        e_done[33] = 1'b1;
        cfg_valid = 1'b1; cfg_half = 12'd4; cfg_bursts = 8'd0; start = 1'b1;
        for (int k = 1; k <= 35; k++) begin
            @(negedge clk);
            start = 1'b0;
            tests_run++;
            if ({sig_out, busy, done, cfg_ready} !== {e_sig[k], e_busy[k], e_done[k], e_rdy[k]}) begin
                $display("FAIL reload_c%0d: got sig/busy/done/rdy=%b expected %b", k,
                         {sig_out, busy, done, cfg_ready}, {e_sig[k], e_busy[k], e_done[k], e_rdy[k]});
                tests_failed++;
            end
            cfg_valid = (k >= 10) && (k <= 17);
            cfg_half  = (k == 10) ? 12'd2 : 12'd3;
            stop      = (k == 28);
        end
        cfg_valid = 1'b0; stop = 1'b0;
    endtask

    // N=2 single period with ena dropped for 7 cycles mid-HIGH.
    task automatic test_ena();
        logic [0:13] e_sig, e_busy, e_done, e_rdy;
        e_sig  = 14'b0_111111111_0000;
        e_busy = 14'b0_11111111111_00;
        e_done = 14'b0_00000000000_10;
        e_rdy  = 14'b1_1_0000000_11111;
        cfg_valid = 1'b1; cfg_half = 12'd2; cfg_bursts = 8'd1; start = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            cfg_valid = 1'b0; start = 1'b0;
            tests_run++;
            if ({sig_out, busy, done, cfg_ready} !== {e_sig[k], e_busy[k], e_done[k], e_rdy[k]}) begin
                $display("FAIL ena_c%0d: got sig/busy/done/rdy=%b expected %b", k,
                         {sig_out, busy, done, cfg_ready}, {e_sig[k], e_busy[k], e_done[k], e_rdy[k]});
                tests_failed++;
            end
            if (k == 1) ena = 1'b0;
            if (k == 8) ena = 1'b1;
        end
        ena = 1'b1;
    endtask

    // Reset during LOW of a continuous run, then a default-config restart.
    task automatic test_midrun_reset();
        cfg_valid = 1'b1; cfg_half = 12'd3; cfg_bursts = 8'd0; start = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0; start = 1'b0;
        repeat (4) @(negedge clk);
        tests_run++;
        if ({sig_out, busy} !== 2'b01) begin
            $display("FAIL mrst_pre: got sig/busy=%b expected 01", {sig_out, busy});
            tests_failed++;
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({sig_out, busy, done, cfg_ready} !== 4'b0001) begin
            $display("FAIL mrst_now: got sig/busy/done/rdy=%b expected 0001", {sig_out, busy, done, cfg_ready});
            tests_failed++;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            tests_run++;
            if ({sig_out, busy, done, cfg_ready} !== 4'b0001) begin
                $display("FAIL mrst_after%0d: got sig/busy/done/rdy=%b expected 0001", k,
                         {sig_out, busy, done, cfg_ready});
                tests_failed++;
            end
        end
        // Active config was cleared: half 0 -> 1-cycle phases, continuous.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tests_run++;
        if ({sig_out, busy} !== 2'b11) begin
            $display("FAIL mrst_restart_h: got sig/busy=%b expected 11", {sig_out, busy});
            tests_failed++;
        end
        @(negedge clk);
        tests_run++;
        if ({sig_out, busy} !== 2'b01) begin
            $display("FAIL mrst_restart_l: got sig/busy=%b expected 01", {sig_out, busy});
            tests_failed++;
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        tests_run = 0; tests_failed = 0;
        rst_n = 1'b0; ena = 1'b1; cfg_valid = 1'b0; cfg_half = '0; cfg_bursts = '0;
        start = 1'b0; stop = 1'b0;
        test_reset();
        test_burst();
        @(negedge clk);
        test_half_zero();
        @(negedge clk);
        test_start_stop();
        @(negedge clk);
        test_reload();
        @(negedge clk);
        test_ena();
        @(negedge clk);
        test_midrun_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
